// File: rtl/mem_slave_ctrl_if.sv
// Bus between the CPU MAR/MDR memory port and mem_slave_ctrl.
// The CPU drives the request side; the slave answers with data, mfc and status.
interface mem_slave_ctrl_if;
  logic        enable;
  logic        rw;
  logic [15:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        mfc;
  logic        busy;
  logic        wp_fault;

  modport master (
    output enable, rw, address, data_in,
    input  data_out, mfc, busy, wp_fault
  );

  modport slave (
    input  enable, rw, address, data_in,
    output data_out, mfc, busy, wp_fault
  );
endinterface

// File: rtl/mem_slave_ctrl.sv
// Memory slave for the CPU MAR/MDR interface: latches a request, waits a fixed
// LATENCY, performs the read/write on an internal 16-bit word array and answers
// with the mfc handshake. Address bits above ADDR_W-1 alias.
// Optional feature macro: MEM_WRITE_PROTECT_EN -- writes below PROTECT_TOP are
// suppressed and flagged on wp_fault; when undefined wp_fault is always 0.
module mem_slave_ctrl #(
  parameter int          ADDR_W      = 8,
  parameter int          LATENCY     = 5,
  parameter logic [15:0] PROTECT_TOP = 16'h0008
) (
  input logic           clk,
  input logic           rst,
  mem_slave_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic [15:0]       req_data;
  logic [15:0]       mem [2**ADDR_W];

  logic [15:0]       data_out_q;
  logic              mfc_q;
  logic              busy_q;
  logic              wp_q;

  logic              fire;
  logic              wr_block;
  logic              do_write;
  logic              unused_bits;

  // The access happens on the WAIT edge where the countdown has expired and
  // the CPU is still requesting; a dropped enable on that edge aborts instead.
  assign fire = (state == WAIT) && bus.enable && (cnt == 8'd0);

`ifdef MEM_WRITE_PROTECT_EN
  assign wr_block = (32'(req_addr) < 32'(PROTECT_TOP));
`else
  assign wr_block = 1'b0;
`endif

  assign do_write = fire && !req_rw && !wr_block;

  // Upper address bits are deliberately ignored (aliasing); PROTECT_TOP is
  // only consulted when write protection is built in.
  assign unused_bits = ^{PROTECT_TOP, bus.address};

  assign bus.data_out = data_out_q;
  assign bus.mfc      = mfc_q;
  assign bus.busy     = busy_q;
  assign bus.wp_fault = wp_q;

  // Capture the request at acceptance so later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.enable) begin
      req_addr <= bus.address[ADDR_W-1:0];
      req_rw   <= bus.rw;
      req_data <= bus.data_in;
    end
  end

  // Array write port; a reset drops the FSM to IDLE so a pending write never lands.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[req_addr] <= req_data;
    end
  end

  // Handshake FSM with registered mfc/busy/data_out/wp_fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      mfc_q      <= 1'b0;
      busy_q     <= 1'b0;
      data_out_q <= 16'h0000;
      wp_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state  <= WAIT;
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
          end
        end
        WAIT: begin
          if (!bus.enable) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            busy_q <= 1'b0;
          end else if (cnt == 8'd0) begin
            state      <= ACK;
            mfc_q      <= 1'b1;
            data_out_q <= req_rw ? mem[req_addr] : 16'h0000;
            wp_q       <= !req_rw && wr_block;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK: begin
          if (!bus.enable) begin
            state      <= IDLE;
            mfc_q      <= 1'b0;
            busy_q     <= 1'b0;
            data_out_q <= 16'h0000;
            wp_q       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= 8'd0;
          mfc_q      <= 1'b0;
          busy_q     <= 1'b0;
          data_out_q <= 16'h0000;
          wp_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// Directed bench for mem_slave_ctrl (ADDR_W=8, LATENCY=5) with a scoreboard
// queue of expected ACK results and a reference word array.
module tb_mem_slave_ctrl;

  localparam int          LAT  = 5;
  localparam logic [15:0] PTOP = 16'h0008;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_slave_ctrl_if bus();

  mem_slave_ctrl #(.ADDR_W(8), .LATENCY(LAT), .PROTECT_TOP(PTOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] data;
    bit          known;
    bit          wp;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [256];
  bit          known [256];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, countdown, ACK held for 'hold' edges, release.
  task automatic req(input bit r, input logic [15:0] a, input logic [15:0] d, input int hold);
    exp_t       e;
    int         n;
    bit         prot;
    logic [7:0] ia;
    ia     = a[7:0];
    prot   = WP && !r && ({8'h00, ia} < PTOP);
    e.wp   = prot;
    e.known = 1'b1;
    e.data = 16'h0000;
    if (r) begin
      e.data  = model[ia];
      e.known = known[ia];
    end else if (!prot) begin
      model[ia] = d;
      known[ia] = 1'b1;
    end
    sb.push_back(e);
    bus.enable  = 1'b1;
    bus.rw      = r;
    bus.address = a;
    bus.data_in = d;
    tick();
    check("accept_busy", 32'(bus.busy), 32'(1));
    check("accept_mfc", 32'(bus.mfc), 32'(0));
    bus.rw      = ~r;
    bus.address = ~a;
    bus.data_in = ~d;
    n = 0;
    while (bus.mfc !== 1'b1 && n < 300) begin
      check("wait_busy", 32'(bus.busy), 32'(1));
      check("wait_data_zero", 32'(bus.data_out), 32'(0));
      tick();
      n++;
    end
    check("mfc_latency", 32'(n), 32'(LAT));
    e = sb.pop_front();
    if (e.known) check("ack_data", 32'(bus.data_out), 32'(e.data));
    else check("ack_data_not_overwritten", 32'(bus.data_out !== 16'hFFFF), 32'(1));
    check("ack_wp", 32'(bus.wp_fault), 32'(e.wp));
    check("ack_busy", 32'(bus.busy), 32'(1));
    repeat (hold) begin
      tick();
      check("ack_hold_mfc", 32'(bus.mfc), 32'(1));
    end
    bus.enable = 1'b0;
    tick();
    check("rel_mfc", 32'(bus.mfc), 32'(0));
    check("rel_busy", 32'(bus.busy), 32'(0));
    check("rel_data", 32'(bus.data_out), 32'(0));
    check("rel_wp", 32'(bus.wp_fault), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.rw      = 1'b0;
    bus.address = 16'h0000;
    bus.data_in = 16'h0000;
    #1;
    check("reset_mfc", 32'(bus.mfc), 32'(0));
    check("reset_busy", 32'(bus.busy), 32'(0));
    check("reset_data", 32'(bus.data_out), 32'(0));
    check("reset_wp", 32'(bus.wp_fault), 32'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // Preload of zeros for the addresses used below.
    req(1'b0, 16'h0010, 16'h0000, 0);
    req(1'b0, 16'h0020, 16'h0000, 0);
    req(1'b0, 16'h0030, 16'h0000, 0);
    if (!WP) req(1'b0, 16'h0003, 16'h0000, 0);

    // Write then read.
    req(1'b0, 16'h0010, 16'hBEEF, 2);
    req(1'b1, 16'h0010, 16'h0000, 1);

    // Abort after two WAIT cycles: nothing written.
    bus.enable  = 1'b1;
    bus.rw      = 1'b0;
    bus.address = 16'h0020;
    bus.data_in = 16'h1234;
    tick();
    check("abort_accept_busy", 32'(bus.busy), 32'(1));
    repeat (2) begin
      tick();
      check("abort_wait_mfc", 32'(bus.mfc), 32'(0));
    end
    bus.enable = 1'b0;
    tick();
    check("abort_busy", 32'(bus.busy), 32'(0));
    repeat (LAT) begin
      tick();
      check("abort_no_mfc", 32'(bus.mfc), 32'(0));
    end
    req(1'b1, 16'h0020, 16'h0000, 0);

    // Address aliasing, including the top of the array.
    req(1'b0, 16'h0110, 16'hA5A5, 0);
    req(1'b1, 16'h0010, 16'h0000, 0);
    req(1'b0, 16'h00FF, 16'h5A3C, 0);
    req(1'b1, 16'hFFFF, 16'h0000, 0);

    // Asynchronous reset three cycles into a write.
    bus.enable  = 1'b1;
    bus.rw      = 1'b0;
    bus.address = 16'h0030;
    bus.data_in = 16'h7777;
    tick();
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    check("rst_wait_mfc", 32'(bus.mfc), 32'(0));
    check("rst_wait_busy", 32'(bus.busy), 32'(0));
    check("rst_wait_data", 32'(bus.data_out), 32'(0));
    bus.enable = 1'b0;
    #2 rst = 1'b0;
    tick();
    req(1'b1, 16'h0030, 16'h0000, 0);

    // Asynchronous reset while a read result is held in ACK.
    bus.enable  = 1'b1;
    bus.rw      = 1'b1;
    bus.address = 16'h0010;
    repeat (LAT + 1) tick();
    check("rst_ack_pre_mfc", 32'(bus.mfc), 32'(1));
    check("rst_ack_pre_data", 32'(bus.data_out), 32'(16'hA5A5));
    #3 rst = 1'b1;
    #1;
    check("rst_ack_mfc", 32'(bus.mfc), 32'(0));
    check("rst_ack_data", 32'(bus.data_out), 32'(0));
    check("rst_ack_busy", 32'(bus.busy), 32'(0));
    bus.enable = 1'b0;
    #2 rst = 1'b0;
    tick();

    // Long ACK hold, then back-to-back request at the minimum period.
    req(1'b1, 16'h0010, 16'h0000, 10);
    req(1'b1, 16'h0110, 16'h0000, 0);

    // Write below the protection boundary.
    req(1'b0, 16'h0003, 16'hFFFF, 0);
    req(1'b1, 16'h0003, 16'h0000, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
